// File: rtl/imem_pkg.sv
// Shared types and constants for the synchronous instruction memory.
package imem_pkg;

  // Sequencer state: CLEAR wipes the bank after reset, RUN serves fetches and loads.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } imem_state_e;

  // Word written by the clear sequence and returned on a faulting fetch (MIPS sll $0,$0,0).
  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

  // MIPS primary opcodes used by bench programs and boot images.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Assemble an I-type instruction word.
  function automatic logic [31:0] mips_itype(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Assemble a J-type instruction word.
  function automatic logic [31:0] mips_jtype(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/imem_bank.sv
// Single-port-write / single-port-read synchronous RAM bank, read-first on
// same-address collisions. Written in the plain template that maps to block RAM.
module imem_bank #(
  parameter int DEPTH_LOG2 = 8,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Synchronous write and enabled registered read; the read samples the old word on a collision.
  // NOTE: the array and rdata have no reset so the tools can infer block RAM; the clear sequencer initialises contents instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instruction_memory_sync.sv
// Synchronous instruction memory for the IF stage: post-reset clear sequencer,
// run-time load port, 1-cycle registered fetch with stall hold and address fault flagging.
module instruction_memory_sync
  import imem_pkg::*;
#(
  parameter int                DEPTH_LOG2 = 8,
  parameter int                DATA_W     = 32,
  parameter logic [31:0]       BASE_ADDR  = 32'h0000_0000,
  parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(IMEM_NOP_WORD)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  input  logic                  stall,
  output logic [DATA_W-1:0]     instr,
  output logic                  instr_valid,
  output logic                  fetch_fault,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [DATA_W-1:0]     load_data,
  output logic                  init_done
);

  localparam int DEPTH = 2**DEPTH_LOG2;

  imem_state_e           state;
  logic [DEPTH_LOG2-1:0] clr_cnt;

  logic [31:0]           byte_off;
  logic [31:0]           word_off;
  logic [DEPTH_LOG2-1:0] fetch_index;
  logic                  addr_fault;
  logic                  accept;
  logic                  bank_re;

  logic                  bank_we;
  logic [DEPTH_LOG2-1:0] bank_waddr;
  logic [DATA_W-1:0]     bank_wdata;
  logic [DATA_W-1:0]     bank_rdata;
  logic                  use_bank;

  // Address decode: the range check looks at the full 32-bit word offset so
  // addresses beyond the bank never alias back onto low words.
  assign byte_off    = fetch_addr - BASE_ADDR;
  assign word_off    = byte_off >> 2;
  assign fetch_index = word_off[DEPTH_LOG2-1:0];
  assign addr_fault  = (fetch_addr[1:0] != 2'b00)
                    || (fetch_addr < BASE_ADDR)
                    || (word_off >= 32'(DEPTH));

  assign accept     = fetch_req && !stall && (state == RUN);
  assign bank_re    = accept && !addr_fault;
  assign load_ready = (state == RUN);
  assign init_done  = (state == RUN);

  // Write-port mux: the clear sequencer owns the port in CLEAR, the load port in RUN.
  // NOTE: every output gets a default first so no path leaves a value unassigned and a latch is inferred.
  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = load_addr;
    bank_wdata = load_data;
    case (state)
      CLEAR: begin
        bank_we    = 1'b1;
        bank_waddr = clr_cnt;
        bank_wdata = NOP_WORD;
      end
      RUN: bank_we = load_valid;
    endcase
  end

  // Clear sequencer: one word per cycle from 0 to DEPTH-1, then RUN until the next reset.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == DEPTH_LOG2'(DEPTH - 1)) state <= RUN;
        end
        RUN: state <= RUN;
      endcase
    end
  end

  imem_bank #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .re    (bank_re),
    .raddr (fetch_index),
    .rdata (bank_rdata)
  );

  // Fetch result registers: stall freezes everything, an accepted request updates
  // valid/fault and selects bank data or NOP, an idle cycle drops valid and fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      use_bank    <= 1'b0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        instr_valid <= 1'b1;
        fetch_fault <= addr_fault;
        use_bank    <= !addr_fault;
      end else begin
        instr_valid <= 1'b0;
        fetch_fault <= 1'b0;
      end
    end
  end

  // Bank read data only advances on a good fetch, so it holds through stalls and idle cycles.
  assign instr = use_bank ? bank_rdata : NOP_WORD;

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed bench for instruction_memory_sync: clear timing, load/fetch, faults,
// stall hold, read-first collision and reset during clear.
module tb_instruction_memory_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_fault;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        init_done;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_memory_sync dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] a, input logic [31:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req  = 1'b0;
  endtask

  // Count cycles until init_done rises, with a bound that counts as a failure if hit.
  task automatic wait_init(input string tag, input int exp_cycles);
    int cnt = 0;
    while (!init_done && cnt < 1000) begin
      step();
      cnt++;
    end
    check(tag, 32'(cnt), 32'(exp_cycles));
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] e_instr,
                             input logic e_valid, input logic e_fault);
    check({tag, ".instr"}, instr, e_instr);
    check({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, e_valid});
    check({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, e_fault});
  endtask

  initial begin
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    stall      = 1'b0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    step();
    step();

    // 1. Reset state, clear duration, first fetch of a cleared word.
    check_fetch("rst", 32'h0, 1'b0, 1'b0);
    check("rst.init_done", {31'b0, init_done}, 32'h0);
    check("rst.load_ready", {31'b0, load_ready}, 32'h0);
    reset = 1'b0;
    wait_init("clear_cycles", 256);
    check("run.load_ready", {31'b0, load_ready}, 32'h1);
    do_fetch(32'h0);
    check_fetch("f0_cleared", 32'h0, 1'b1, 1'b0);
    step();
    check_fetch("idle", 32'h0, 1'b0, 1'b0);

    // 2. Load a small program and fetch it back with 1-cycle latency.
    do_load(8'd0, 32'h2004_0005);
    do_load(8'd2, 32'h0C00_0004);
    do_load(8'd1, 32'h0085_1020);
    do_fetch(32'h0);
    check_fetch("f0", 32'h2004_0005, 1'b1, 1'b0);
    do_fetch(32'h8);
    check_fetch("f8", 32'h0C00_0004, 1'b1, 1'b0);
    step();
    check_fetch("idle_keep", 32'h0C00_0004, 1'b0, 1'b0);

    // 3. Faults: misaligned, past the end, wrapped offset; last valid word is fine.
    do_fetch(32'h0000_0002);
    check_fetch("misaligned", 32'h0, 1'b1, 1'b1);
    do_fetch(32'h0000_0400);
    check_fetch("out_of_range", 32'h0, 1'b1, 1'b1);
    do_fetch(32'hFFFF_FFFC);
    check_fetch("no_alias", 32'h0, 1'b1, 1'b1);
    do_fetch(32'h0000_03FC);
    check_fetch("last_word", 32'h0, 1'b1, 1'b0);

    // 4. Stall holds the 0x4 result for 3 cycles while a load proceeds underneath.
    do_fetch(32'h4);
    check_fetch("pre_stall", 32'h0085_1020, 1'b1, 1'b0);
    stall      = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h8;
    load_valid = 1'b1;
    load_addr  = 8'd3;
    load_data  = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      step();
      load_valid = 1'b0;
      check_fetch($sformatf("stall%0d", i), 32'h0085_1020, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    fetch_req = 1'b0;
    check_fetch("post_stall", 32'h0C00_0004, 1'b1, 1'b0);
    do_fetch(32'hC);
    check_fetch("load_in_stall", 32'h1111_1111, 1'b1, 1'b0);

    // 5. Same-cycle load and fetch of word 1 returns the old contents first.
    load_valid = 1'b1;
    load_addr  = 8'd1;
    load_data  = 32'hDEAD_BEEF;
    do_fetch(32'h4);
    load_valid = 1'b0;
    check_fetch("read_first", 32'h0085_1020, 1'b1, 1'b0);
    do_fetch(32'h4);
    check_fetch("after_write", 32'hDEAD_BEEF, 1'b1, 1'b0);

    // 6. Reset asserted mid-clear restarts the sequence; loads offered during clear are dropped.
    reset = 1'b1;
    #1;
    check_fetch("async_rst", 32'h0, 1'b0, 1'b0);
    check("async_rst.init_done", {31'b0, init_done}, 32'h0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) step();
    check("mid_clear.init_done", {31'b0, init_done}, 32'h0);
    reset = 1'b1;
    step();
    reset      = 1'b0;
    load_valid = 1'b1;
    load_addr  = 8'd0;
    load_data  = 32'h1234_5678;
    check("clear.load_ready", {31'b0, load_ready}, 32'h0);
    wait_init("restart_cycles", 256);
    load_valid = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    step();
    fetch_req  = 1'b0;
    check_fetch("dropped_load", 32'h0, 1'b1, 1'b0);
    do_fetch(32'h4);
    check_fetch("recleared", 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
